alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller: 4x4-bit register file feeding an external ALU through IDLE/READ/EXEC/WB.
// Optional output wb_zero is built only when ALU_ISSUE_ZERO_FLAG_EN is defined.
module alu_issue_ctrl #(
    parameter logic [3:0] RESET_VAL = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [2:0] instr_op,
    input  logic [1:0] instr_rd,
    input  logic [1:0] instr_rs1,
    input  logic [1:0] instr_rs2,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_result,
    output logic       wb_valid,
    output logic [1:0] wb_rd,
    output logic [3:0] wb_data,
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    output logic       wb_zero,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t     state;
    state_t     state_next;
    logic       accept;
    logic [2:0] op_p0;
    logic [1:0] rd_p0;
    logic [1:0] rs1_p0;
    logic [1:0] rs2_p0;
    logic [3:0] result_p1;
    logic [3:0] rf [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (instr_valid) state_next = READ;
            READ:    state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state == IDLE);
        busy        = (state != IDLE);
        accept      = instr_valid && (state == IDLE);
    end

    // Instruction capture at handshake; EXEC samples the combinational ALU result.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0  <= instr_op;
            rd_p0  <= instr_rd;
            rs1_p0 <= instr_rs1;
            rs2_p0 <= instr_rs2;
        end
        if (state == EXEC) result_p1 <= alu_result;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a  <= 4'h0;
            alu_b  <= 4'h0;
            alu_op <= 3'b000;
        end else if (state == READ) begin
            alu_a  <= rf[rs1_p0];
            alu_b  <= rf[rs2_p0];
            alu_op <= op_p0;
        end
    end

    // Register file commit and write-back strobe share the WB edge, so the next READ sees the new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) rf[i] <= RESET_VAL;
        end else if (state == WB) begin
            rf[rd_p0] <= result_p1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_rd    <= 2'd0;
            wb_data  <= 4'h0;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
            wb_zero  <= 1'b0;
`endif
        end else begin
            wb_valid <= (state == WB);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
            wb_zero  <= (state == WB) && (result_p1 == 4'h0);
`endif
            if (state == WB) begin
                wb_rd   <= rd_p0;
                wb_data <= result_p1;
            end
        end
    end

endmodule
